// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern blocks: default pattern count,
// selector width and the sequencer state encoding.
package led_pkg;

  localparam int NUM_PATTERNS = 6;
  localparam int SEL_W        = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AUTO   = 2'd1,
    MANUAL = 2'd2
  } led_state_e;

endpackage

// File: rtl/led_dwell_timer.sv
// Dwell counter: counts while en_i, wraps at DWELL_CYCLES-1 and flags that
// terminal cycle combinationally so the sequencer can step on the same edge.
module led_dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DWELL_W      = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  assign expire_o = en_i && (count_q == DWELL_W'(DWELL_CYCLES - 1));

  // Clear takes priority over counting so a button press restarts the dwell.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = expire_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Pattern selector for the LED pattern mux: timed auto stepping or manual
// next/prev stepping, modulo NUM_PATTERNS, with a registered wrap pulse.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int NUM_PATTERNS = led_pkg::NUM_PATTERNS,
  parameter int SEL_W        = led_pkg::SEL_W,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DWELL_W      = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode_auto,
  input  logic             btn_next,
  input  logic             btn_prev,
  output logic [SEL_W-1:0] selector,
  output logic             active,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PATTERNS - 1);

  led_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wrap_q, wrap_d;
  logic             active_q;

  logic nextPress;
  logic prevPress;
  logic stepUp;
  logic stepDown;
  logic timerEn;
  logic timerClear;
  logic timerExpire;

  // Both buttons in the same cycle cancel out entirely.
  assign nextPress = btn_next && !btn_prev;
  assign prevPress = btn_prev && !btn_next;

  // Dwell only runs while staying in AUTO; any step by button, mode change,
  // disable or non-AUTO state zeroes it.
  assign timerEn    = enable && mode_auto && (state_q == AUTO);
  assign timerClear = !enable || (state_q != AUTO) || !mode_auto || nextPress || prevPress;

  led_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .DWELL_W      (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timerClear),
    .en_i     (timerEn),
    .expire_o (timerExpire)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wrap_d   = 1'b0;
    stepUp   = 1'b0;
    stepDown = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_d   = '0;
        state_d = mode_auto ? AUTO : MANUAL;
      end
      AUTO: begin
        stepUp   = nextPress || (timerExpire && !prevPress);
        stepDown = prevPress;
        if (!mode_auto) state_d = MANUAL;
      end
      MANUAL: begin
        stepUp   = nextPress;
        stepDown = prevPress;
        if (mode_auto) state_d = AUTO;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    if (stepUp) begin
      if (sel_q == LAST_SEL) begin
        sel_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sel_d = sel_q + 1'b1;
      end
    end else if (stepDown) begin
      sel_d = (sel_q == '0) ? LAST_SEL : sel_q - 1'b1;
    end

    // Disable overrides every other event, including a pending IDLE exit.
    if (!enable) begin
      state_d = IDLE;
      sel_d   = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      wrap_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wrap_q   <= wrap_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign selector = sel_q;
  assign active   = active_q;
  assign wrap     = wrap_q;

endmodule
